riffa_tx_streamer: RTL and testbench



---
 rtl/riffa_pkg.sv | 17 +
 rtl/riffa_tx_streamer.sv | 121 ++++++++++++
 tb/tb_riffa_tx_streamer.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riffa_pkg.sv
// Shared definitions for the RIFFA channel TX streamer: word sizing,
// request field widths and the state codes exposed on debug_state.
package riffa_pkg;

    localparam int RIFFA_WORD_BITS = 32;
    localparam int LEN_W = 32;
    localparam int OFF_W = 31;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_XFER  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ABORT = 3'd4
    } tx_state_t;

endpackage

// File: rtl/riffa_tx_streamer.sv
// RIFFA channel transmitter: streams one host-bound transaction from a
// FWFT source onto CHNL_TX_*, with ACK handshake and ACK timeout.
module riffa_tx_streamer
    import riffa_pkg::*;
#(
    parameter int C_PCI_DATA_WIDTH = 64,
    parameter int C_ACK_TIMEOUT = 65535
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_start,
    input  logic [LEN_W-1:0]            req_len,
    input  logic [OFF_W-1:0]            req_off,
    input  logic                        req_last,
    output logic                        req_busy,
    output logic                        req_done,
    output logic                        req_err,
    input  logic [C_PCI_DATA_WIDTH-1:0] src_data,
    input  logic                        src_valid,
    output logic                        src_ready,
    output logic                        CHNL_TX_CLK,
    output logic                        CHNL_TX,
    input  logic                        CHNL_TX_ACK,
    output logic                        CHNL_TX_LAST,
    output logic [LEN_W-1:0]            CHNL_TX_LEN,
    output logic [OFF_W-1:0]            CHNL_TX_OFF,
    output logic [C_PCI_DATA_WIDTH-1:0] CHNL_TX_DATA,
    output logic                        CHNL_TX_DATA_VALID,
    input  logic                        CHNL_TX_DATA_REN,
    output logic [7:0]                  debug_state
);

    localparam int WPB = C_PCI_DATA_WIDTH / RIFFA_WORD_BITS;
    localparam int SHIFT = $clog2(WPB);
    localparam logic [LEN_W:0] ROUND = (LEN_W + 1)'(WPB - 1);
    localparam logic [31:0] TIMEOUT = 32'(C_ACK_TIMEOUT);

    tx_state_t state, state_nxt;
    logic [LEN_W:0] beats_left, beats_nxt, req_beats;
    logic [31:0] to_cnt, to_nxt;
    logic load, xfer, beat;

    // 33-bit math keeps req_len = 0xFFFFFFFF from wrapping
    assign req_beats = ({1'b0, req_len} + ROUND) >> SHIFT;

    // Gate with rst so no pop is issued on the reset edge
    assign xfer = (state == ST_XFER) & ~rst;
    assign CHNL_TX_DATA_VALID = xfer & src_valid;
    assign src_ready = xfer & CHNL_TX_DATA_REN;
    assign beat = CHNL_TX_DATA_VALID & CHNL_TX_DATA_REN;

    assign CHNL_TX_CLK = clk;
    assign CHNL_TX_DATA = src_data;
    assign debug_state = 8'(state);

    always_comb begin
        state_nxt = state;
        beats_nxt = beats_left;
        to_nxt = to_cnt;
        load = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (req_start) begin
                    state_nxt = ST_REQ;
                    beats_nxt = req_beats;
                    to_nxt = '0;
                    load = 1'b1;
                end
            end
            ST_REQ: begin
                if (CHNL_TX_ACK) begin
                    state_nxt = (beats_left == '0) ? ST_DONE : ST_XFER;
                end else begin
                    to_nxt = to_cnt + 32'd1;
                    if (TIMEOUT != 32'd0 && to_nxt == TIMEOUT) begin
                        state_nxt = ST_ABORT;
                    end
                end
            end
            ST_XFER: begin
                if (beat) begin
                    beats_nxt = beats_left - 1'b1;
                    if (beats_left == (LEN_W + 1)'(1)) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE, ST_ABORT: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            beats_left <= '0;
            to_cnt <= '0;
            CHNL_TX <= 1'b0;
            req_busy <= 1'b0;
            req_done <= 1'b0;
            req_err <= 1'b0;
            CHNL_TX_LEN <= '0;
            CHNL_TX_OFF <= '0;
            CHNL_TX_LAST <= 1'b0;
        end else begin
            state <= state_nxt;
            beats_left <= beats_nxt;
            to_cnt <= to_nxt;
            CHNL_TX <= (state_nxt == ST_REQ) || (state_nxt == ST_XFER);
            req_busy <= state_nxt != ST_IDLE;
            req_done <= state_nxt == ST_DONE;
            req_err <= state_nxt == ST_ABORT;
            if (load) begin
                CHNL_TX_LEN <= req_len;
                CHNL_TX_OFF <= req_off;
                CHNL_TX_LAST <= req_last;
            end
        end
    end

endmodule

// File: tb/tb_riffa_tx_streamer.sv
// Scoreboard bench for riffa_tx_streamer: randomized source/host behaviour
// against a queue-based model of which source words must reach the host.
module tb_riffa_tx_streamer;

    localparam int DW = 64;
    localparam int WPB = DW / 32;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst;
    logic req_start;
    logic [31:0] req_len;
    logic [30:0] req_off;
    logic req_last;
    logic req_busy, req_done, req_err;
    logic [DW-1:0] src_data;
    logic src_valid, src_ready;
    logic chnl_clk, chnl_tx, chnl_ack, chnl_last;
    logic [31:0] chnl_len;
    logic [30:0] chnl_off;
    logic [DW-1:0] chnl_data;
    logic chnl_valid, chnl_ren;
    logic [7:0] debug_state;

    riffa_tx_streamer #(
        .C_PCI_DATA_WIDTH(DW),
        .C_ACK_TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_start(req_start),
        .req_len(req_len),
        .req_off(req_off),
        .req_last(req_last),
        .req_busy(req_busy),
        .req_done(req_done),
        .req_err(req_err),
        .src_data(src_data),
        .src_valid(src_valid),
        .src_ready(src_ready),
        .CHNL_TX_CLK(chnl_clk),
        .CHNL_TX(chnl_tx),
        .CHNL_TX_ACK(chnl_ack),
        .CHNL_TX_LAST(chnl_last),
        .CHNL_TX_LEN(chnl_len),
        .CHNL_TX_OFF(chnl_off),
        .CHNL_TX_DATA(chnl_data),
        .CHNL_TX_DATA_VALID(chnl_valid),
        .CHNL_TX_DATA_REN(chnl_ren),
        .debug_state(debug_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pops = 0;
    int beats_seen = 0;
    int ren_mode = 0;
    bit gap_en = 1'b0;
    bit drop_chk = 1'b0;
    logic [31:0] cur_len = '0;
    logic [DW-1:0] src_q[$];
    logic [DW-1:0] exp_beats[$];
    int exp_evt[$];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int model_beats(input longint len);
        return int'((len + WPB - 1) / WPB);
    endfunction

    // Source FIFO and host REN model
    initial begin : drv
        bit pop_now;
        src_valid = 1'b0;
        src_data = '0;
        chnl_ren = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            pop_now = src_valid && src_ready;
            @(posedge clk);
            #1;
            if (pop_now) begin
                void'(src_q.pop_front());
                pops++;
            end
            case (ren_mode)
                0: chnl_ren = 1'b1;
                1: chnl_ren = 1'($urandom_range(0, 1));
                default: chnl_ren = ~chnl_ren;
            endcase
            src_valid = (!gap_en || $urandom_range(0, 3) != 0) &&
                        src_q.size() > 0;
            src_data = (src_q.size() > 0) ? src_q[0] : '0;
        end
    end

    // Monitor: pops expected beats/events whenever the DUT presents them
    initial begin : mon
        int code;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (drop_chk) begin
                    check("tx_drop_after_last", chnl_tx, 1'b0);
                    check("done_after_last", req_done, 1'b1);
                    drop_chk = 1'b0;
                end
                if (chnl_valid && chnl_ren) begin
                    beats_seen++;
                    if (exp_beats.size() == 0) begin
                        check("extra_beat", 1'b1, 1'b0);
                    end else begin
                        check("beat_data", chnl_data, exp_beats.pop_front());
                        if (exp_beats.size() == 0) drop_chk = 1'b1;
                    end
                end
                if (req_done || req_err) begin
                    code = req_done ? 1 : 2;
                    if (req_done && req_err) code = 3;
                    if (exp_evt.size() == 0) begin
                        check("unexpected_evt", 64'(code), 64'd0);
                    end else begin
                        check("evt", 64'(code), 64'(exp_evt.pop_front()));
                    end
                end
                if (chnl_tx) check("len_stable", chnl_len, cur_len);
            end
        end
    end

    task automatic preload(input int n, input int nexp);
        logic [DW-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = {$urandom, $urandom};
            src_q.push_back(w);
            if (i < nexp) exp_beats.push_back(w);
        end
    endtask

    task automatic launch(input logic [31:0] len, input logic [30:0] off,
                          input logic last);
        @(posedge clk);
        #1;
        cur_len = len;
        req_start = 1'b1;
        req_len = len;
        req_off = off;
        req_last = last;
        @(posedge clk);
        #1;
        req_start = 1'b0;
        req_len = $urandom;
        req_off = 31'($urandom);
        req_last = ~last;
        @(negedge clk);
        check("tx_latency", chnl_tx, 1'b1);
        check("state_req", debug_state, 8'd1);
        check("off_cap", chnl_off, off);
        check("last_cap", chnl_last, last);
    endtask

    task automatic ack_after(input int n);
        repeat (n) @(posedge clk);
        #1;
        chnl_ack = 1'b1;
        @(posedge clk);
        #1;
        chnl_ack = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (req_busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check(name, 1'b0, 1'b1);
    endtask

    task automatic flush();
        @(posedge clk);
        #1;
        src_q.delete();
    endtask

    initial begin : wdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int p0, b0, n, cyc;
        rst = 1'b1;
        req_start = 1'b0;
        req_len = '0;
        req_off = '0;
        req_last = 1'b0;
        chnl_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state", debug_state, 8'd0);
        check("rst_tx", chnl_tx, 1'b0);
        check("rst_busy", req_busy, 1'b0);
        check("rst_done", req_done, 1'b0);
        check("rst_err", req_err, 1'b0);
        check("rst_valid", chnl_valid, 1'b0);
        check("rst_ready", src_ready, 1'b0);
        check("rst_len", chnl_len, 32'd0);
        check("rst_off", chnl_off, 31'd0);
        check("rst_last", chnl_last, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic 8 words = 4 beats, ACK 3 cycles after CHNL_TX
        ren_mode = 0;
        gap_en = 1'b0;
        preload(4, model_beats(8));
        exp_evt.push_back(1);
        p0 = pops;
        b0 = beats_seen;
        launch(32'd8, 31'($urandom), 1'b0);
        ack_after(3);
        wait_idle(100, "basic_wait");
        check("basic_beats", 64'(beats_seen - b0), 64'd4);
        check("basic_pops", 64'(pops - p0), 64'd4);
        check("basic_src_empty", 64'(src_q.size()), 64'd0);

        // Odd length with REN toggling and gapped source
        ren_mode = 2;
        gap_en = 1'b1;
        preload(5, model_beats(5));
        exp_evt.push_back(1);
        p0 = pops;
        launch(32'd5, 31'($urandom), 1'b1);
        ack_after(2);
        wait_idle(200, "odd_wait");
        check("odd_pops", 64'(pops - p0), 64'd3);
        check("odd_src_left", 64'(src_q.size()), 64'd2);
        flush();

        // Zero length: ACK leads straight to done, source untouched
        ren_mode = 0;
        gap_en = 1'b0;
        preload(2, model_beats(0));
        exp_evt.push_back(1);
        p0 = pops;
        launch(32'd0, 31'($urandom), 1'b1);
        ack_after(2);
        wait_idle(50, "zero_wait");
        check("zero_pops", 64'(pops - p0), 64'd0);
        flush();

        // ACK timeout with REN high during REQ
        preload(2, 0);
        exp_evt.push_back(2);
        p0 = pops;
        launch(32'd8, 31'($urandom), 1'b0);
        cyc = 1;
        n = 0;
        while (req_err !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
            if (chnl_tx === 1'b1) cyc++;
        end
        check("timeout_seen", req_err, 1'b1);
        check("timeout_cycles", 64'(cyc), 64'(TMO));
        check("timeout_tx_low", chnl_tx, 1'b0);
        check("timeout_state", debug_state, 8'd4);
        wait_idle(10, "timeout_wait");
        check("timeout_pops", 64'(pops - p0), 64'd0);
        flush();

        // ACK on the last REQ cycle before timeout wins
        preload(1, model_beats(2));
        exp_evt.push_back(1);
        launch(32'd2, 31'($urandom), 1'b0);
        ack_after(TMO - 1);
        wait_idle(50, "ackwin_wait");
        check("ackwin_src_empty", 64'(src_q.size()), 64'd0);

        // Interference: stray req_start/ACK during XFER
        ren_mode = 1;
        preload(4, model_beats(8));
        exp_evt.push_back(1);
        p0 = pops;
        launch(32'd8, 31'($urandom), 1'b0);
        ack_after(1);
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (req_done === 1'b1 || req_busy !== 1'b1) begin
                req_start = 1'b0;
                chnl_ack = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
            req_start = 1'($urandom_range(0, 1));
            chnl_ack = 1'($urandom_range(0, 1));
        end
        req_start = 1'b0;
        chnl_ack = 1'b0;
        wait_idle(10, "intf_wait");
        repeat (3) @(negedge clk);
        check("intf_no_queue", req_busy, 1'b0);
        check("intf_pops", 64'(pops - p0), 64'd4);

        // Reset after 2 of 4 beats
        ren_mode = 0;
        gap_en = 1'b0;
        preload(4, 4);
        exp_evt.push_back(1);
        p0 = pops;
        launch(32'd8, 31'($urandom), 1'b1);
        ack_after(1);
        n = 0;
        while (pops - p0 < 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mrst_state", debug_state, 8'd0);
        check("mrst_tx", chnl_tx, 1'b0);
        check("mrst_busy", req_busy, 1'b0);
        check("mrst_len", chnl_len, 32'd0);
        check("mrst_last", chnl_last, 1'b0);
        check("mrst_valid", chnl_valid, 1'b0);
        check("mrst_pops", 64'(pops - p0), 64'd2);
        check("mrst_exp_left", 64'(exp_beats.size()), 64'd2);
        exp_beats.delete();
        exp_evt.delete();
        cur_len = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        src_q.delete();
        repeat (3) @(negedge clk);

        check("end_exp_beats", 64'(exp_beats.size()), 64'd0);
        check("end_exp_evt", 64'(exp_evt.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
